aes_mix_col_engine: RTL and testbench
=====================================

# aes_mix_col_engine

Parametrised AES column-mixing engine for the round datapath. Performs forward MixColumns or InvMixColumns on one 128-bit state, with the mode selected per block. GF(2^8) products are computed in logic rather than ROM. The engine processes COLS_PER_CYCLE columns per clock and uses valid/ready handshakes on both sides with full backpressure. It sits between the (inv_)shift_rows stage and add_round_key in both the encrypt and decrypt pipelines.

## Interface
- COLS_PER_CYCLE, 1: columns processed per clock; legal values 1, 2, 4; elaboration error otherwise.
- NCOL (derived, not overridable): 4 / COLS_PER_CYCLE.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_inv are valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  state; byte b = in_data[127-8b -: 8]; column c = bytes 4c..4c+3; row r = byte 4c+r.
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns; sampled at accept.
- abort  in  1  synchronous flush; drops any block in flight.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  128  result, same byte ordering as in_data.
- busy  out  1  state != IDLE.

## Operation
- Forward: out_r = 02·a_r ^ 03·a_{r+1} ^ a_{r+2} ^ a_{r+3}, indices mod 4.
- Inverse: out_r = 0e·a_r ^ 0b·a_{r+1} ^ 0d·a_{r+2} ^ 09·a_{r+3}.
- All products use xtime with reduction polynomial 0x11B. Results are 8-bit exact, with no carries.
- State machine has three states.
  - IDLE: in_ready=1. On accept, capture in_data and in_inv, clear grp_cnt, go to CALC.
  - CALC: each cycle, mix columns grp_cnt·COLS_PER_CYCLE to grp_cnt·COLS_PER_CYCLE+COLS_PER_CYCLE-1 into the result register, then increment grp_cnt. When grp_cnt==NCOL-1, go to HOLD.
  - HOLD: out_valid=1.
    - If out_ready and in_valid: accept a new block in the same cycle and go to CALC.
    - If out_ready only: go to IDLE.
    - Otherwise: stay in HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and forced to 0 while rst is low.
- out_data is held stable while out_valid=1 and out_ready=0.
- Result bytes not yet written in CALC are don't-care internally. out_data reads 0 whenever out_valid=0.
- abort, from any state: next state is IDLE, out_valid=0, result cleared.
  - abort overrides a simultaneous accept: in_ready=0 while abort=1.
  - abort overrides a simultaneous output handshake: no transfer is counted.
- in_inv is ignored outside the accept cycle. A mode change mid-block has no effect.

## Timing
- Reset (rst low, asynchronous): state=IDLE, grp_cnt=0, out_valid=0, out_data=0, busy=0, in_ready=0.
- After rst deasserts, in_ready=1 on the first cycle.
- Latency: block accepted at edge E0 presents out_valid=1 after edge E_NCOL.
  - COLS_PER_CYCLE=1: 4 cycles.
  - COLS_PER_CYCLE=2: 2 cycles.
  - COLS_PER_CYCLE=4: 1 cycle.
- Maximum throughput, with out_ready held at 1: one block per NCOL+1 cycles.
- Reset asserted mid-CALC or mid-HOLD: the block is lost and no partial out_valid pulse appears.
- No combinational path from in_valid or in_data to out_*. The only combinational path from out_ready is to in_ready.

## Structure
- Package aes_pkg holds:
  - function gf_xtime(byte)
  - constant AES_POLY = 8'h1B
  - typedef aes_state_t (logic [15:0][7:0])
  - typedef aes_col_t (logic [3:0][7:0])
  - state enum mixcol_state_e {IDLE, CALC, HOLD}
- Sub-module aes_mix_col_word: purely combinational, one column. Inputs col[31:0] and inv; output mixed[31:0].
  - The inverse is built from shared xtime chains (x2, x4, x8) so forward and inverse share logic.
  - Instantiated COLS_PER_CYCLE times, fed by a column mux on grp_cnt.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0. Required: out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid 4 cycles after accept.
- Inverse round-trip for each COLS_PER_CYCLE in {1,2,4}: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1. Required: out_data=db135345_f20a225c_01010101_c6c6c6c6, with latency 4, 2 and 1 respectively.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: out_data stable, in_ready=0, busy=1. Then raise out_ready with in_valid=1 and a new block: both handshakes occur in the same cycle and the second result follows NCOL cycles later.
- Back-to-back mixed modes: 100 random blocks with random in_inv, out_ready=1. Required: each output equals the golden model, and throughput is exactly NCOL+1 cycles per block.
- abort asserted during CALC (grp_cnt=1), and again during HOLD together with out_ready=1. Required: next cycle IDLE, out_valid=0, out_data=0, no transfer, and the next block processes correctly.
- Asynchronous reset pulse mid-CALC, off the clock edge. Required: out_valid and out_data drop to 0 immediately, and in_ready=0 while rst is low.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES column-mixing types, GF(2^8) helpers and FSM encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]  aes_col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } mixcol_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // State byte n sits in element 15-n, so column c row r is element 15-4c-r.
  function automatic aes_col_t get_col(input aes_state_t s, input int c);
    aes_col_t col;
    int       base;
    base = 4 * int'(c[1:0]);
    for (int r = 0; r < 4; r++) begin
      col[3 - r] = s[15 - base - r];
    end
    return col;
  endfunction

  function automatic aes_state_t put_col(input aes_state_t s, input int c, input aes_col_t col);
    aes_state_t res;
    int         base;
    res  = s;
    base = 4 * int'(c[1:0]);
    for (int r = 0; r < 4; r++) begin
      res[15 - base - r] = col[3 - r];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_mix_col_engine_if.sv
// Block-level handshake bundle between the shift-rows stage, the engine and add-round-key.
interface aes_mix_col_engine_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, in_inv, abort, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_inv, abort, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_mix_col_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in bits 31:24).
module aes_mix_col_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] mixed
);

  aes_col_t col_s;
  logic [7:0] row_s [4];
  logic [7:0] x2_s [4];
  logic [7:0] x8_sum_s;

  assign col_s = col;

  // Shared xtime chains: the inverse adds 04*(a_r^a_{r+2}) ^ 08*(a0^a1^a2^a3) to the forward result.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_s[r] = col_s[3 - r];
      x2_s[r]  = gf_xtime(row_s[r]);
    end
    x8_sum_s = gf_xtime(gf_xtime(gf_xtime(row_s[0] ^ row_s[1] ^ row_s[2] ^ row_s[3])));
    mixed    = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      mixed[31 - 8*r -: 8] =
          x2_s[r] ^ x2_s[(r + 1) % 4] ^ row_s[(r + 1) % 4] ^ row_s[(r + 2) % 4] ^ row_s[(r + 3) % 4]
        ^ (inv ? (gf_xtime(gf_xtime(row_s[r] ^ row_s[(r + 2) % 4])) ^ x8_sum_s) : 8'h00);
    end
  end

endmodule

// File: rtl/aes_mix_col_engine.sv
// AES column-mixing engine: captures one 128-bit state, mixes COLS_PER_CYCLE columns per
// clock and holds the result until the downstream stage takes it.
module aes_mix_col_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  aes_mix_col_engine_if.slave bus
);

  localparam int         NCOL     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(NCOL - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mixcol_state_e state_r;
  mixcol_state_e state_nxt_s;
  logic [1:0]    grp_cnt_r;
  aes_state_t    data_r;
  aes_state_t    res_r;
  aes_state_t    res_nxt_s;
  logic          inv_r;
  logic          in_ready_s;
  logic          accept_s;
  logic          last_grp_s;
  logic          out_valid_s;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in_s;
  logic [COLS_PER_CYCLE-1:0][31:0] col_out_s;

  assign last_grp_s = (grp_cnt_r == LAST_GRP);
  // Held low during reset and abort so neither can coincide with an accept.
  assign in_ready_s = rst && !bus.abort &&
                      ((state_r == IDLE) || ((state_r == HOLD) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_in_s[k] = get_col(data_r, int'(grp_cnt_r) * COLS_PER_CYCLE + k);
    aes_mix_col_word u_word (
      .col   (col_in_s[k]),
      .inv   (inv_r),
      .mixed (col_out_s[k])
    );
  end

  // Merge this cycle's column group into the result.
  always_comb begin
    res_nxt_s = res_r;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      res_nxt_s = put_col(res_nxt_s, int'(grp_cnt_r) * COLS_PER_CYCLE + k, col_out_s[k]);
    end
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = accept_s ? CALC : IDLE;
        CALC:    state_nxt_s = last_grp_s ? HOLD : CALC;
        HOLD: begin
          if (bus.out_ready) begin
            state_nxt_s = accept_s ? CALC : IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Block capture, group counter and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r    <= '0;
      inv_r     <= 1'b0;
      grp_cnt_r <= 2'd0;
      res_r     <= '0;
    end else if (bus.abort) begin
      data_r    <= '0;
      inv_r     <= 1'b0;
      grp_cnt_r <= 2'd0;
      res_r     <= '0;
    end else if (accept_s) begin
      data_r    <= bus.in_data;
      inv_r     <= bus.in_inv;
      grp_cnt_r <= 2'd0;
    end else if (state_r == CALC) begin
      res_r     <= res_nxt_s;
      grp_cnt_r <= last_grp_s ? 2'd0 : 2'(grp_cnt_r + 2'd1);
    end
  end

  // Masking with abort keeps a flushed block from completing an output handshake.
  assign out_valid_s   = (state_r == HOLD) && !bus.abort;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_valid_s ? 128'(res_r) : 128'd0;
  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_aes_mix_col_engine.sv
// Self-checking bench: three engines (1, 2 and 4 columns per cycle) against a GF(2^8) reference model.
module tb_aes_mix_col_engine;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         in_valid  [3];
  logic         in_inv    [3];
  logic         abort     [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] out_data  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mix_col_engine_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_inv    = in_inv[g];
    assign bus.abort     = abort[g];
    assign bus.out_ready = out_ready[g];
    assign bus.in_data   = in_data[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign busy[g]       = bus.busy;
    assign out_data[g]   = bus.out_data;
    aes_mix_col_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [8:0] x;
    r = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11B;
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   a  [16];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] o;
    for (int b = 0; b < 16; b++) a[b] = s[127 - 8*b -: 8];
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[k], a[4*c + (r + k) % 4]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic int ncol(input int d);
    return 4 >> d;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
  endtask

  // One block through engine d with out_ready high; checks latency, data and return to idle.
  task automatic run_block(input int d, input logic [127:0] din, input logic inv, output logic [127:0] got);
    int lat;
    logic [127:0] exp;
    exp = mix_ref(din, inv);
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_data[d]   = din;
    in_inv[d]    = inv;
    #1;
    chk("rb_in_ready", 128'(in_ready[d]), 128'd1);
    tick();
    in_valid[d] = 1'b0;
    in_inv[d]   = ~inv;
    in_data[d]  = rand128();
    wait_valid(d, lat);
    chk("rb_latency", 128'(lat), 128'(ncol(d)));
    got = out_data[d];
    chk("rb_data", got, exp);
    tick();
    chk("rb_idle_valid", 128'(out_valid[d]), 128'd0);
    chk("rb_idle_data", out_data[d], 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    logic [127:0] got, e1, e2, r1, r2, exp_q;
    logic [127:0] q[$];
    int lat, sent, recv, cyc, last_out;
    logic acc, xfer;

    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_inv[d] = 1'b0; abort[d] = 1'b0;
      out_ready[d] = 1'b1; in_data[d] = 128'd0;
    end

    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 128'(in_ready[d]), 128'd0);
      chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
      chk("rst_out_data", out_data[d], 128'd0);
      chk("rst_busy", 128'(busy[d]), 128'd0);
    end
    #20 rst = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) chk("post_rst_in_ready", 128'(in_ready[d]), 128'd1);

    // Known-answer vectors
    run_block(0, VEC_A, 1'b0, got);
    chk("kat_forward", got, VEC_B);
    for (int d = 0; d < 3; d++) begin
      run_block(d, VEC_B, 1'b1, got);
      chk("kat_inverse", got, VEC_A);
    end

    // Backpressure, then simultaneous output and input handshakes
    for (int d = 0; d < 3; d++) begin
      r1 = rand128(); r2 = rand128();
      e1 = mix_ref(r1, 1'b0); e2 = mix_ref(r2, 1'b1);
      out_ready[d] = 1'b0; in_valid[d] = 1'b1; in_data[d] = r1; in_inv[d] = 1'b0;
      tick();
      in_valid[d] = 1'b0;
      wait_valid(d, lat);
      chk("bp_latency", 128'(lat), 128'(ncol(d)));
      for (int i = 0; i < 10; i++) begin
        chk("bp_data_stable", out_data[d], e1);
        chk("bp_in_ready", 128'(in_ready[d]), 128'd0);
        chk("bp_busy", 128'(busy[d]), 128'd1);
        tick();
      end
      out_ready[d] = 1'b1; in_valid[d] = 1'b1; in_data[d] = r2; in_inv[d] = 1'b1;
      #1;
      chk("bp_dual_in_ready", 128'(in_ready[d]), 128'd1);
      chk("bp_dual_out_valid", 128'(out_valid[d]), 128'd1);
      chk("bp_dual_out_data", out_data[d], e1);
      tick();
      in_valid[d] = 1'b0; in_inv[d] = 1'b0;
      wait_valid(d, lat);
      chk("bp_second_latency", 128'(lat), 128'(ncol(d)));
      chk("bp_second_data", out_data[d], e2);
      tick();
    end

    // Abort during CALC with grp_cnt=1 (engines with at least two groups)
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; in_data[d] = rand128(); in_inv[d] = 1'b0;
      tick();
      in_valid[d] = 1'b0;
      tick();
      abort[d] = 1'b1; in_valid[d] = 1'b1;
      #1;
      chk("abort_calc_in_ready", 128'(in_ready[d]), 128'd0);
      tick();
      abort[d] = 1'b0; in_valid[d] = 1'b0;
      chk("abort_calc_busy", 128'(busy[d]), 128'd0);
      chk("abort_calc_out_valid", 128'(out_valid[d]), 128'd0);
      chk("abort_calc_out_data", out_data[d], 128'd0);
      run_block(d, rand128(), 1'($urandom_range(0, 1)), got);
    end

    // Abort during HOLD together with out_ready and in_valid
    for (int d = 0; d < 3; d++) begin
      out_ready[d] = 1'b0; in_valid[d] = 1'b1; in_data[d] = rand128(); in_inv[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      wait_valid(d, lat);
      chk("abort_hold_reached", 128'(out_valid[d]), 128'd1);
      out_ready[d] = 1'b1; abort[d] = 1'b1; in_valid[d] = 1'b1;
      #1;
      chk("abort_hold_in_ready", 128'(in_ready[d]), 128'd0);
      chk("abort_hold_no_xfer", 128'(out_valid[d]), 128'd0);
      tick();
      abort[d] = 1'b0; in_valid[d] = 1'b0;
      chk("abort_hold_busy", 128'(busy[d]), 128'd0);
      chk("abort_hold_out_valid", 128'(out_valid[d]), 128'd0);
      chk("abort_hold_out_data", out_data[d], 128'd0);
      run_block(d, rand128(), 1'($urandom_range(0, 1)), got);
    end

    // Back-to-back random blocks with mixed modes
    for (int d = 0; d < 3; d++) begin
      q.delete();
      sent = 0; recv = 0; cyc = 0; last_out = -1;
      out_ready[d] = 1'b1; in_valid[d] = 1'b1;
      in_data[d] = rand128(); in_inv[d] = 1'($urandom_range(0, 1));
      while (recv < 100 && cyc < 2000) begin
        #1;
        acc  = in_valid[d] && in_ready[d];
        xfer = out_valid[d] && out_ready[d];
        if (xfer) begin
          exp_q = (q.size() > 0) ? q.pop_front() : 128'bx;
          chk("stream_data", out_data[d], exp_q);
          if (last_out >= 0) chk("stream_period", 128'(cyc - last_out), 128'(ncol(d) + 1));
          last_out = cyc;
          recv++;
        end
        if (acc) begin
          q.push_back(mix_ref(in_data[d], in_inv[d]));
          sent++;
        end
        tick();
        cyc++;
        if (acc) begin
          if (sent < 100) begin
            in_data[d] = rand128(); in_inv[d] = 1'($urandom_range(0, 1));
          end else begin
            in_valid[d] = 1'b0;
          end
        end
      end
      chk("stream_count", 128'(recv), 128'd100);
      in_valid[d] = 1'b0;
      tick();
    end

    // Asynchronous reset mid-CALC, off the clock edge
    in_valid[0] = 1'b1; in_data[0] = rand128(); in_inv[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_calc_busy", 128'(busy[0]), 128'd0);
    chk("arst_calc_out_valid", 128'(out_valid[0]), 128'd0);
    for (int d = 0; d < 3; d++) chk("arst_in_ready", 128'(in_ready[d]), 128'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_pulse", 128'(out_valid[0]), 128'd0);
    end

    // Asynchronous reset mid-HOLD drops a presented result at once
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = rand128(); in_inv[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait_valid(0, lat);
    chk("arst_hold_reached", 128'(out_valid[0]), 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_hold_out_valid", 128'(out_valid[0]), 128'd0);
    chk("arst_hold_out_data", out_data[0], 128'd0);
    chk("arst_hold_in_ready", 128'(in_ready[0]), 128'd0);
    #1 rst = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    chk("arst_release_in_ready", 128'(in_ready[0]), 128'd1);
    run_block(0, rand128(), 1'b0, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
